afifo_rd_streamer: RTL and testbench
====================================

AFIFO_RD_STREAMER -- requirements
Module: afifo_rd_streamer

Interface
REQ-001 The block SHALL have one clock and one reset. Reset SHALL be synchronous and active-high.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the FIFO read data width and stream data width.
REQ-003 Parameter PKT_LEN, default 16, SHALL set the words per packet (legal range >= 1).
REQ-004 Parameter CNT_WIDTH, default 16, SHALL set the width of pkt_count.
REQ-005 Ports SHALL be (name, direction, width, meaning):
- rclk, input, 1: read-domain clock; all state updates on its rising edge.
- rrst, input, 1: synchronous active-high reset.
- en, input, 1: streaming enable.
- rempty, input, 1: FIFO empty flag.
- rdata, input, DATA_WIDTH: FIFO head word; valid whenever rempty=0 (first-word-fall-through).
- rinc, output, 1: FIFO pop request.
- m_valid, output, 1: stream word valid.
- m_ready, input, 1: downstream accept.
- m_data, output, DATA_WIDTH: stream word.
- m_last, output, 1: last word of packet.
- busy, output, 1: block active or holding data.
- pkt_count, output, CNT_WIDTH: completed packets delivered downstream.

Function
REQ-006 A FIFO word SHALL be consumed at a rclk edge only when rinc=1 and rempty=0. rinc SHALL never be 1 while rempty=1.
REQ-007 rinc SHALL equal (state in RUN or DRAIN) AND rempty=0 AND occupancy<2.
- occupancy is the registered count (0..2) of a 2-entry output buffer.
- rinc SHALL have no combinational path from m_ready or en.
REQ-008 A popped word SHALL enter the output buffer at the pop edge and appear on m_data in the following cycle (1-cycle latency).
REQ-009 m_valid SHALL be 1 exactly when occupancy != 0. m_data and m_last SHALL present the oldest entry.
REQ-010 While m_valid=1 and m_ready=0, m_valid, m_data and m_last SHALL hold stable.
REQ-011 Simultaneous pop and output handshake SHALL leave occupancy unchanged.
- Sustained throughput SHALL be 1 word/cycle when rempty=0 and m_ready=1.
REQ-012 A beat counter (0..PKT_LEN-1) SHALL increment on every pop and wrap to 0 after PKT_LEN-1.
- The word popped at count PKT_LEN-1 SHALL be tagged m_last=1; all others m_last=0.
- The counter SHALL hold across FIFO-empty gaps.
REQ-013 The FSM SHALL have states IDLE, RUN and DRAIN, with these transitions:
- IDLE->RUN when en=1.
- RUN with en=0: to IDLE if the post-pop beat count is 0, else to DRAIN.
- DRAIN->IDLE on the edge popping the last-tagged word.
- en SHALL be ignored in DRAIN.
REQ-014 en falling while in RUN SHALL still allow that cycle's pop, since state is registered.
REQ-015 In IDLE no pops SHALL occur. Buffered words SHALL still drain to m_data.
REQ-016 pkt_count SHALL increment on each output handshake (m_valid & m_ready & m_last) and saturate at all-ones.
REQ-017 busy SHALL equal (state != IDLE) OR (occupancy != 0).

Reset
REQ-018 While rrst=1, the block SHALL hold these values: state=IDLE, occupancy=0, beat count=0, pkt_count=0, rinc=0, m_valid=0, m_last=0, m_data=0, busy=0.
REQ-019 Reset asserted mid-packet SHALL discard buffered words and the partial beat count without producing m_last. The next packet boundary SHALL count from the first pop after reset.
REQ-020 The first pop after reset release SHALL occur no earlier than the cycle after the FSM enters RUN.

Verification
REQ-021 Reset: rrst=1 for 3 cycles with rempty=0, en=1 -> rinc=0, m_valid=0, pkt_count=0, busy=0 throughout.
REQ-022 Stream: FIFO holds words 0..15, en=1, m_ready=1 -> the following SHALL hold:
- m_data=0..15 on consecutive cycles, the first one cycle after the first rinc.
- m_last=1 only with data 15.
- pkt_count=1.
REQ-023 Backpressure: m_ready=0 with FIFO non-empty -> exactly 2 pops, then rinc=0 and m_data=0 held. m_ready=1 -> 0,1,2,... with no loss or duplication.
REQ-024 Drain: en=0 in the cycle after word 5 is popped -> pops continue through word 15 (m_last=1), then IDLE with rinc=0 while rempty=0.
REQ-025 Gaps: rempty toggles every cycle over 32 words -> rinc=0 whenever rempty=1. m_last SHALL appear on words 15 and 31, and pkt_count=2.
REQ-026 Mid-reset: rrst pulsed after 7 pops, then en=1 -> first m_last on the 16th word popped after reset.

Source files
------------

// File: rtl/afifo_rd_streamer.sv
// Read-side streamer: pops a first-word-fall-through FIFO into a 2-entry skid buffer
// and emits a valid/ready stream framed into PKT_LEN-word packets.
module afifo_rd_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  en,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [1:0]             occ_r;
    logic [1:0]             occ_next_s;
    logic [DATA_WIDTH-1:0]  buf_data_r [2];
    logic [1:0]             buf_last_r;
    logic                   wr_ptr_r;
    logic                   rd_ptr_r;
    logic [BEAT_W-1:0]      beat_r;
    logic [BEAT_W-1:0]      beat_next_s;
    logic [CNT_WIDTH-1:0]   pkt_r;
    logic                   pop_s;
    logic                   pop_last_s;
    logic                   valid_s;
    logic                   hs_s;

    // Pop depends only on registered state and the FIFO flag, never on m_ready or en.
    // Outputs are forced to their reset values for the whole time rrst is high.
    assign pop_s      = ((state_r == RUN) || (state_r == DRAIN)) && !rempty
                        && (occ_r < 2'd2) && !rrst;
    assign pop_last_s = pop_s && (beat_r == BEAT_MAX);
    assign valid_s    = (occ_r != 2'd0) && !rrst;
    assign hs_s       = valid_s && m_ready;

    assign rinc      = pop_s;
    assign m_valid   = valid_s;
    assign m_data    = rrst ? {DATA_WIDTH{1'b0}} : buf_data_r[rd_ptr_r];
    assign m_last    = valid_s && buf_last_r[rd_ptr_r];
    assign busy      = !rrst && ((state_r != IDLE) || (occ_r != 2'd0));
    assign pkt_count = rrst ? {CNT_WIDTH{1'b0}} : pkt_r;

    // Next beat count, buffer occupancy and FSM state.
    always_comb begin
        beat_next_s  = beat_r;
        occ_next_s   = occ_r;
        state_next_s = state_r;

        if (pop_s) begin
            if (pop_last_s) begin
                beat_next_s = {BEAT_W{1'b0}};
            end else begin
                beat_next_s = beat_r + BEAT_W'(1);
            end
        end else begin
            beat_next_s = beat_r;
        end

        case ({pop_s, hs_s})
            2'b10:   occ_next_s = occ_r + 2'd1;
            2'b01:   occ_next_s = occ_r - 2'd1;
            default: occ_next_s = occ_r;
        endcase

        case (state_r)
            IDLE: begin
                if (en) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                // Stopping mid-packet finishes the packet first so framing stays intact.
                if (en) begin
                    state_next_s = RUN;
                end else if (beat_next_s == {BEAT_W{1'b0}}) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, skid buffer and packet counter registers.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_r       <= IDLE;
            occ_r         <= 2'd0;
            beat_r        <= {BEAT_W{1'b0}};
            pkt_r         <= {CNT_WIDTH{1'b0}};
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            buf_data_r[0] <= {DATA_WIDTH{1'b0}};
            buf_data_r[1] <= {DATA_WIDTH{1'b0}};
            buf_last_r    <= 2'b00;
        end else begin
            state_r <= state_next_s;
            occ_r   <= occ_next_s;
            beat_r  <= beat_next_s;
            if (pop_s) begin
                buf_data_r[wr_ptr_r] <= rdata;
                buf_last_r[wr_ptr_r] <= pop_last_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (hs_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            if (hs_s && m_last && (pkt_r != {CNT_WIDTH{1'b1}})) begin
                pkt_r <= pkt_r + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_afifo_rd_streamer.sv
// Bench for afifo_rd_streamer: directed scenarios plus random traffic, all checked
// against a queue-based packet-stream reference model.
module tb_afifo_rd_streamer;

    localparam int DW   = 32;
    localparam int PL   = 16;
    localparam int CW   = 3;
    localparam int PMAX = (1 << CW) - 1;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          en = 1'b0;
    logic          rempty = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          rinc;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic [CW-1:0] pkt_count;

    afifo_rd_streamer #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
        .rclk(rclk), .rrst(rrst), .en(en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .pkt_count(pkt_count)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    word_t  q[$];
    int     mode;
    int     beat;
    int     pkt;
    int     head;
    int     checks;
    int     errors;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, then advance FIFO and model.
    task automatic cycle(input logic r, input logic e, input logic emp, input logic rdy);
        logic          exp_pop;
        logic          dut_pop;
        logic          hs;
        logic          popped_last;
        logic [DW-1:0] d;
        rrst = r; en = e; rempty = emp; m_ready = rdy; rdata = DW'(head);
        #1;
        exp_pop = !r && (mode != 0) && !emp && (q.size() < 2);
        if (r) begin
            check_eq("rst_rinc", 32'(rinc), 32'd0);
            check_eq("rst_valid", 32'(m_valid), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_pkt", 32'(pkt_count), 32'd0);
            check_eq("rst_data", m_data, 32'd0);
            check_eq("rst_last", 32'(m_last), 32'd0);
        end else begin
            check_eq("rinc", 32'(rinc), 32'(exp_pop));
            check_eq("m_valid", 32'(m_valid), 32'(q.size() != 0));
            check_eq("busy", 32'(busy), 32'((mode != 0) || (q.size() != 0)));
            check_eq("pkt_count", 32'(pkt_count), 32'(pkt));
            if (q.size() != 0) begin
                check_eq("m_data", m_data, q[0].d);
                check_eq("m_last", 32'(m_last), 32'(q[0].l));
            end
        end
        dut_pop = rinc && !rempty;
        d = rdata;
        @(posedge rclk);
        if (dut_pop) head++;
        if (r) begin
            q.delete(); mode = 0; beat = 0; pkt = 0;
        end else begin
            hs = (q.size() != 0) && rdy;
            if (hs) begin
                if (q[0].l && pkt < PMAX) pkt++;
                void'(q.pop_front());
            end
            popped_last = 1'b0;
            if (exp_pop) begin
                popped_last = (beat == PL - 1);
                q.push_back('{d: d, l: popped_last});
                beat = popped_last ? 0 : beat + 1;
            end
            case (mode)
                0: if (e) mode = 1;
                1: if (!e) mode = (beat == 0) ? 0 : 2;
                2: if (popped_last) mode = 0;
                default: mode = 0;
            endcase
        end
        @(negedge rclk);
    endtask

    task automatic do_reset();
        head = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic e_r;
        checks = 0; errors = 0; mode = 0; beat = 0; pkt = 0; head = 0;
        @(negedge rclk);

        // Reset held with FIFO non-empty and enable high
        do_reset();

        // Straight 16-word packet
        for (int i = 0; i < 22; i++) cycle(1'b0, 1'b1, head >= 16, 1'b1);
        check_eq("stream_pkt", 32'(pkt_count), 32'd1);
        check_eq("stream_words", 32'(head), 32'd16);

        // Backpressure: only two words may be taken
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("bp_pops", 32'(head), 32'd2);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);

        // Drain: drop enable right after word 5 is popped
        do_reset();
        for (int k = 0; k < 50 && head < 6; k++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("drain_start", 32'(head), 32'd6);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("drain_words", 32'(head), 32'd16);
        check_eq("drain_pkt", 32'(pkt_count), 32'd1);

        // Gaps: empty flag toggles every cycle over 32 words
        do_reset();
        for (int k = 0; k < 100 && head < 32; k++) cycle(1'b0, 1'b1, k[0], 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("gap_words", 32'(head), 32'd32);
        check_eq("gap_pkt", 32'(pkt_count), 32'd2);

        // Reset mid-packet after 7 pops
        do_reset();
        for (int k = 0; k < 50 && head < 7; k++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("mid_pops", 32'(head), 32'd7);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, head >= 23, 1'b1);
        check_eq("mid_pkt", 32'(pkt_count), 32'd1);

        // Random traffic, long enough to saturate the narrow packet counter
        do_reset();
        head = int'($urandom_range(0, 32'h7fff_0000));
        e_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) e_r = ~e_r;
            cycle($urandom_range(0, 199) == 0, e_r,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
